mem_arbiter: RTL and testbench

- Shares the single-port word-addressable memory model between NUM_PORTS requesters, e.g. a fetch unit, an LSU and a DMA/testbench loader.
- Each requester gets a valid/ready request channel and a one-cycle response pulse.
- Selection is round-robin; one transaction is in flight at a time.
- The arbiter drives the memory read/write ports with registered commands and routes the memory's next-cycle read data back to the owning requester.

---
 rtl/config_pkg.sv | 28 ++
 rtl/rr_picker.sv | 44 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : config_pkg
//  Description : Shared configuration constants and types. This file carries
//                the memory-arbiter port count, the arbiter state encoding and
//                a small modulo helper for round-robin index arithmetic.
//  Revision    : 1.0 - initial release of memory arbiter additions
// ============================================================================
package config_pkg;

    // Default number of requesters sharing the memory port.
    localparam int MEMARB_PORTS = 4;

    // Memory arbiter state encoding.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_CMD     = 2'd1,
        ARB_RD_WAIT = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_e;

    // Wrap an index that may exceed the port count by less than one full lap.
    function automatic int wrap_idx(input int value, input int modulus);
        return (value >= modulus) ? (value - modulus) : value;
    endfunction

endpackage : config_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin picker. Rotates the request vector
//                so the pointer position becomes bit 0, finds the first set
//                bit, then rotates the offset back to a port index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import config_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic                 o_grant_valid,
    output logic [IDX_W-1:0]     o_grant_idx
);

    logic [NUM_PORTS-1:0] w_rot;
    logic [IDX_W-1:0]     w_off;
    logic                 w_found;

    // Rotate, find-first from the pointer, and map the offset back to a port.
    always_comb begin
        w_rot   = '0;
        w_off   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_rot[i] = i_req[wrap_idx(int'(i_rr_ptr) + i, NUM_PORTS)];
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDX_W'(i);
            end
        end
        o_grant_valid = w_found;
        o_grant_idx   = IDX_W'(wrap_idx(int'(w_off) + int'(i_rr_ptr), NUM_PORTS));
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one single-port word memory
//                between NUM_PORTS requesters. One transaction in flight;
//                memory commands and responses are driven from registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import config_pkg::*;
#(
    parameter int NUM_PORTS = MEMARB_PORTS,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          busy,
    output logic                          err,
    output logic                          mem_read_en,
    output logic [ADDR_W-1:0]             mem_read_addr,
    input  logic [DATA_W-1:0]             mem_read_data,
    input  logic                          mem_read_valid,
    output logic                          mem_write_en,
    output logic [ADDR_W-1:0]             mem_write_addr,
    output logic [DATA_W-1:0]             mem_write_data
);

    localparam int c_IDX_W = $clog2(NUM_PORTS);

    arb_state_e           r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_owner;
    logic                 r_we;
    logic                 r_post_rst;
    logic                 r_err;
    logic                 r_mem_read_en;
    logic                 r_mem_write_en;
    logic [ADDR_W-1:0]    r_mem_read_addr;
    logic [ADDR_W-1:0]    r_mem_write_addr;
    logic [DATA_W-1:0]    r_mem_write_data;
    logic [NUM_PORTS-1:0] r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;

    logic                 w_grant_valid;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_accept;
    logic [NUM_PORTS-1:0] w_ready;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (c_IDX_W)
    ) u_picker (
        .i_req         (req_valid),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // Select the granted request fields and drive the single ready bit.
    always_comb begin
        w_sel_we    = req_we[w_grant_idx];
        w_sel_addr  = req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[int'(w_grant_idx)*DATA_W +: DATA_W];
        w_accept    = (r_state == ARB_IDLE) && !rst && w_grant_valid;
        w_ready     = '0;
        if (w_accept) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    // Transaction FSM; all memory commands and responses are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ARB_IDLE;
            r_rr_ptr         <= '0;
            r_owner          <= '0;
            r_we             <= 1'b0;
            r_post_rst       <= 1'b1;
            r_err            <= 1'b0;
            r_mem_read_en    <= 1'b0;
            r_mem_write_en   <= 1'b0;
            r_mem_read_addr  <= '0;
            r_mem_write_addr <= '0;
            r_mem_write_data <= '0;
            r_rsp_valid      <= '0;
            r_rsp_data       <= '0;
        end else begin
            r_post_rst  <= 1'b0;
            r_rsp_valid <= '0;
            // Read data outside RD_WAIT has no owner; the cycle right after
            // reset may still carry a read started before reset.
            if (mem_read_valid && (r_state != ARB_RD_WAIT) && !r_post_rst) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_owner          <= w_grant_idx;
                        r_we             <= w_sel_we;
                        r_rr_ptr         <= c_IDX_W'(wrap_idx(int'(w_grant_idx) + 1, NUM_PORTS));
                        r_mem_read_en    <= !w_sel_we;
                        r_mem_write_en   <= w_sel_we;
                        r_mem_read_addr  <= w_sel_addr;
                        r_mem_write_addr <= w_sel_addr;
                        r_mem_write_data <= w_sel_wdata;
                        r_state          <= ARB_CMD;
                    end
                end
                ARB_CMD: begin
                    r_mem_read_en  <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    if (r_we) begin
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_data           <= '0;
                        r_state              <= ARB_RESP;
                    end else begin
                        r_state <= ARB_RD_WAIT;
                    end
                end
                ARB_RD_WAIT: begin
                    if (mem_read_valid) begin
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_rsp_data           <= mem_read_data;
                        r_state              <= ARB_RESP;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = w_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign busy           = (r_state != ARB_IDLE) && !rst;
    assign err            = r_err;
    assign mem_read_en    = r_mem_read_en;
    assign mem_read_addr  = r_mem_read_addr;
    assign mem_write_en   = r_mem_write_en;
    assign mem_write_addr = r_mem_write_addr;
    assign mem_write_data = r_mem_write_data;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a 64-word
//                next-cycle-response memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NP        = 4;
    localparam int MEM_WORDS = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     rv, rwe;
    logic [31:0]       raddr [NP];
    logic [31:0]       rwd   [NP];
    logic              spur;

    logic [NP-1:0]     req_ready, rsp_valid;
    logic [NP*32-1:0]  req_addr, req_wdata;
    logic [31:0]       rsp_data;
    logic              busy, err;
    logic              mem_read_en, mem_write_en, mem_read_valid;
    logic [31:0]       mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

    logic [31:0]       mem [MEM_WORDS];
    logic              mv = 1'b0;
    logic [31:0]       last_rd_addr = '0;

    int total = 0;
    int bad   = 0;

    assign req_addr  = {raddr[3], raddr[2], raddr[1], raddr[0]};
    assign req_wdata = {rwd[3], rwd[2], rwd[1], rwd[0]};
    assign mem_read_valid = mv | spur;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (rv),
        .req_ready      (req_ready),
        .req_we         (rwe),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .busy           (busy),
        .err            (err),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_read_valid (mem_read_valid),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    // Memory model: writes commit at the edge, reads answer one cycle later.
    always @(posedge clk) begin
        if (mem_write_en && (mem_write_addr < MEM_WORDS))
            mem[mem_write_addr[5:0]] <= mem_write_data;
        mv <= mem_read_en;
        mem_read_data <= (mem_read_en && (mem_read_addr < MEM_WORDS)) ? mem[mem_read_addr[5:0]] : 32'h0;
        if (mem_read_en) last_rd_addr <= mem_read_addr;
    end

    function automatic logic [NP-1:0] oh(input int k);
        logic [NP-1:0] one;
        one = 1;
        return one << k;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction on port p with latency and command checks.
    task automatic do_txn(input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_data);
        int n;
        int lat;
        rv[p] = 1'b1; rwe[p] = we; raddr[p] = a; rwd[p] = d;
        #1;
        n = 0;
        while (req_ready !== oh(p) && n < 10) begin @(posedge clk); #1; n++; end
        chk("txn_ready", req_ready, oh(p));
        @(posedge clk); #1;
        rv[p] = 1'b0;
        chk("cmd_busy", busy, 1);
        chk("cmd_ready", req_ready, 0);
        if (we) begin
            chk("cmd_wen", mem_write_en, 1);
            chk("cmd_waddr", mem_write_addr, a);
            chk("cmd_wdata", mem_write_data, d);
        end else begin
            chk("cmd_ren", mem_read_en, 1);
            chk("cmd_raddr", mem_read_addr, a);
        end
        lat = 1;
        while (rsp_valid === '0 && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, we ? 2 : 3);
        chk("rsp_valid", rsp_valid, oh(p));
        chk("rsp_data", rsp_data, exp_data);
        @(posedge clk); #1;
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("rsp_data_hold", rsp_data, exp_data);
        chk("idle_busy", busy, 0);
    endtask

    // Expect port e to win among the currently raised reads; serve it.
    task automatic pick(input int e);
        int n;
        n = 0;
        while (req_ready === '0 && n < 10) begin @(posedge clk); #1; n++; end
        chk("pick_grant", req_ready, oh(e));
        @(posedge clk); #1;
        rv[e] = 1'b0;
        n = 0;
        while (rsp_valid === '0 && n < 10) begin @(posedge clk); #1; n++; end
        chk("pick_rsp", rsp_valid, oh(e));
        chk("pick_data", rsp_data, 32'h100 + e);
        @(posedge clk); #1;
    endtask

    initial begin
        int grants, rsps, last, cyc, eg, er;

        rst = 1'b1; spur = 1'b0; rv = '1; rwe = '0;
        for (int k = 0; k < NP; k++) begin raddr[k] = k; rwd[k] = '0; end

        // Reset state, with all ports requesting to expose ready gating.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_en", {mem_read_en, mem_write_en}, 0);
        chk("rst_mem_addr", mem_read_addr, 0);
        rv = '0; rst = 1'b0;
        @(posedge clk); #1;

        // Single write then read on port 1.
        do_txn(1, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0);
        do_txn(1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF);

        // Preload words 0..3 with 0x100+k.
        for (int k = 0; k < NP; k++) do_txn(k, 1'b1, k, 32'h100 + k, 32'h0);

        // Round robin with all ports reading continuously from rr_ptr=0.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < NP; k++) begin rwe[k] = 1'b0; raddr[k] = k; end
        rv = '1;
        #1;
        grants = 0; rsps = 0; last = -1; cyc = 0; eg = 0; er = 0;
        while ((grants < 8 || rsps < 8) && cyc < 80) begin
            if (req_ready !== '0) begin
                chk("rr_grant", req_ready, oh(eg % NP));
                if (last >= 0) chk("rr_spacing", cyc - last, 4);
                last = cyc; grants++; eg++;
            end
            if (rsp_valid !== '0) begin
                chk("rr_rsp", rsp_valid, oh(er % NP));
                chk("rr_data", rsp_data, 32'h100 + (er % NP));
                rsps++; er++;
            end
            @(posedge clk); #1;
            cyc++;
            if (grants >= 8) rv = '0;
        end
        chk("rr_count", {grants[15:0], rsps[15:0]}, {16'd8, 16'd8});

        // Pointer wrap: port 2 served leaves rr_ptr=3.
        do_txn(2, 1'b0, 32'd2, 32'h0, 32'h102);
        rv = 4'b1001; #1;
        pick(3);
        pick(0);
        do_txn(2, 1'b0, 32'd2, 32'h0, 32'h102);
        rv = 4'b1001; #1;
        pick(3);
        rv = '0;
        @(posedge clk); #1;

        // Out-of-range read passes the address through and returns 0.
        do_txn(1, 1'b0, MEM_WORDS + 1, 32'h0, 32'h0);
        chk("oor_addr", last_rd_addr, MEM_WORDS + 1);
        chk("oor_err", err, 0);

        // Reset during RD_WAIT abandons the read.
        rwe[0] = 1'b0; raddr[0] = 32'd1; rv[0] = 1'b1; #1;
        chk("mid_ready", req_ready, oh(0));
        @(posedge clk); #1; rv[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_rdwait_busy", busy, 1);
        rst = 1'b1; rv[1] = 1'b1; #1;
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_ren", mem_read_en, 0);
        rst = 1'b0; rv = '0; spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        chk("post_rst_rsp", rsp_valid, 0);
        @(posedge clk); #1;
        chk("post_rst_err", err, 0);
        chk("post_rst_busy", busy, 0);
        raddr[0] = 32'd0; raddr[3] = 32'd3;
        rv = 4'b1001; #1;
        pick(0);
        rv = '0;
        @(posedge clk); #1;
        do_txn(2, 1'b0, 32'd2, 32'h0, 32'h102);

        // Spurious read-valid in IDLE sets the sticky error.
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        chk("spur_err", err, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("spur_err_sticky", err, 1);
        do_txn(3, 1'b1, 32'd7, 32'h12345678, 32'h0);
        do_txn(3, 1'b0, 32'd7, 32'h0, 32'h12345678);
        chk("spur_err_final", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
